// File: rtl/painterengine_gpu_dma_reader_mc.sv
// Multi-channel AXI4 burst read DMA: one-hot selected requester, 4 KB-safe bursts,
// slave-response / RLAST / timeout checking, per-channel streaming with backpressure.
module painterengine_gpu_dma_reader_mc #(
    parameter int CHANNELS     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 256,
    parameter int TIMEOUT_BITS = 19
) (
    input  logic                           i_wire_clock,
    input  logic                           i_wire_reset,
    input  logic                           i_wire_start,
    input  logic                           i_wire_ack,
    input  logic [CHANNELS-1:0]            i_wire_router,
    input  logic [CHANNELS*32-1:0]         i_wire_address,
    input  logic [CHANNELS*32-1:0]         i_wire_length,
    output logic [CHANNELS*DATA_WIDTH-1:0] o_wire_data,
    output logic [CHANNELS-1:0]            o_wire_data_valid,
    input  logic [CHANNELS-1:0]            i_wire_data_next,
    output logic                           o_wire_busy,
    output logic                           o_wire_done,
    output logic                           o_wire_error,
    output logic [2:0]                     o_wire_error_type,
    output logic                           o_wire_M_AXI_ARID,
    output logic [31:0]                    o_wire_M_AXI_ARADDR,
    output logic [7:0]                     o_wire_M_AXI_ARLEN,
    output logic [2:0]                     o_wire_M_AXI_ARSIZE,
    output logic [1:0]                     o_wire_M_AXI_ARBURST,
    output logic                           o_wire_M_AXI_ARLOCK,
    output logic [3:0]                     o_wire_M_AXI_ARCACHE,
    output logic [2:0]                     o_wire_M_AXI_ARPROT,
    output logic [3:0]                     o_wire_M_AXI_ARQOS,
    output logic                           o_wire_M_AXI_ARVALID,
    input  logic                           i_wire_M_AXI_ARREADY,
    input  logic                           i_wire_M_AXI_RID,
    input  logic [DATA_WIDTH-1:0]          i_wire_M_AXI_RDATA,
    input  logic [1:0]                     i_wire_M_AXI_RRESP,
    input  logic                           i_wire_M_AXI_RLAST,
    input  logic                           i_wire_M_AXI_RVALID,
    output logic                           o_wire_M_AXI_RREADY
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int SIZE_LOG = $clog2(BYTES);
    localparam int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ROUTER   = 3'd1;
    localparam logic [2:0] ERR_PARAM    = 3'd2;
    localparam logic [2:0] ERR_AR_TMO   = 3'd3;
    localparam logic [2:0] ERR_R_TMO    = 3'd4;
    localparam logic [2:0] ERR_PROTOCOL = 3'd5;
    localparam logic [2:0] ERR_RESP     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_CALC, ST_ADDR, ST_DATA, ST_DONE, ST_ERROR
    } state_t;

    state_t                  state, state_next;
    logic [2:0]              error_type_q, error_type_next;
    logic [IDX_W-1:0]        idx_q, sel_idx;
    logic [31:0]             addr_q, remain_q, sel_addr, sel_len;
    logic [12:0]             burst_q, beat_q, beats4k, burst_calc;
    logic [TIMEOUT_BITS-1:0] tcnt_q;
    logic                    arvalid_q;
    logic [31:0]             araddr_q;
    logic [7:0]              arlen_q;
    logic                    router_onehot, ar_hs, r_rdy, r_hs, last_cnt, timeout_hit;
    logic                    unused_rid;

    // Beats in this burst: the smallest of what is left, the burst cap and the room to the 4 KB page end.
    function automatic logic [12:0] sat_burst(input logic [31:0] remain, input logic [12:0] room);
        logic [12:0] cap;
        cap = (13'(MAX_BURST) < room) ? 13'(MAX_BURST) : room;
        return (remain < {19'd0, cap}) ? remain[12:0] : cap;
    endfunction

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_idx  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i_wire_router[i]) begin
                sel_addr = i_wire_address[i*32 +: 32];
                sel_len  = i_wire_length[i*32 +: 32];
                sel_idx  = IDX_W'(i);
            end
        end
    end

    assign router_onehot = (i_wire_router != '0) &&
                           ((i_wire_router & (i_wire_router - CHANNELS'(1))) == '0);
    assign beats4k     = (13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE_LOG;
    assign burst_calc  = sat_burst(remain_q, beats4k);
    assign ar_hs       = (state == ST_ADDR) && arvalid_q && i_wire_M_AXI_ARREADY;
    assign r_rdy       = (state == ST_DATA) && i_wire_data_next[idx_q];
    assign r_hs        = r_rdy && i_wire_M_AXI_RVALID;
    assign last_cnt    = (beat_q == burst_q - 13'd1);
    assign timeout_hit = tcnt_q[TIMEOUT_BITS-1];
    assign unused_rid  = i_wire_M_AXI_RID;

    always_comb begin
        state_next      = state;
        error_type_next = error_type_q;
        case (state)
            ST_IDLE: if (i_wire_start) begin
                if (router_onehot) begin
                    state_next = ST_CHECK;
                end else begin
                    state_next      = ST_ERROR;
                    error_type_next = ERR_ROUTER;
                end
            end
            ST_CHECK: begin
                if ((addr_q[SIZE_LOG-1:0] != '0) || (remain_q == '0)) begin
                    state_next      = ST_ERROR;
                    error_type_next = ERR_PARAM;
                end else begin
                    state_next = ST_CALC;
                end
            end
            ST_CALC: state_next = ST_ADDR;
            ST_ADDR: begin
                if (ar_hs) begin
                    state_next = ST_DATA;
                end else if (timeout_hit) begin
                    state_next      = ST_ERROR;
                    error_type_next = ERR_AR_TMO;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    if (i_wire_M_AXI_RRESP != 2'b00) begin
                        state_next      = ST_ERROR;
                        error_type_next = ERR_RESP;
                    end else if (i_wire_M_AXI_RLAST != last_cnt) begin
                        state_next      = ST_ERROR;
                        error_type_next = ERR_PROTOCOL;
                    end else if (last_cnt) begin
                        state_next = (remain_q == {19'd0, burst_q}) ? ST_DONE : ST_CALC;
                    end
                end else if (timeout_hit) begin
                    state_next      = ST_ERROR;
                    error_type_next = ERR_R_TMO;
                end
            end
            ST_DONE: if (i_wire_ack) state_next = ST_IDLE;
            ST_ERROR: if (i_wire_ack) begin
                state_next      = ST_IDLE;
                error_type_next = ERR_NONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state        <= ST_IDLE;
            error_type_q <= ERR_NONE;
        end else begin
            state        <= state_next;
            error_type_q <= error_type_next;
        end
    end

    // Stall counter only measures uninterrupted waiting within one ADDR or DATA visit.
    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset || ar_hs || r_hs || (state_next != state)) begin
            tcnt_q <= '0;
        end else if ((state == ST_ADDR) || (state == ST_DATA)) begin
            tcnt_q <= tcnt_q + TIMEOUT_BITS'(1);
        end
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
        end else if (state == ST_CALC) begin
            arvalid_q <= 1'b1;
            araddr_q  <= addr_q;
            arlen_q   <= 8'(burst_calc - 13'd1);
        end else if ((state == ST_ADDR) && (state_next != ST_ADDR)) begin
            arvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge i_wire_clock) begin
        case (state)
            ST_IDLE: if (i_wire_start) begin
                idx_q    <= sel_idx;
                addr_q   <= sel_addr;
                remain_q <= sel_len;
            end
            ST_CALC: burst_q <= burst_calc;
            ST_ADDR: if (ar_hs) beat_q <= '0;
            ST_DATA: if (r_hs) begin
                beat_q <= beat_q + 13'd1;
                if (last_cnt) begin
                    addr_q   <= addr_q + ({19'd0, burst_q} << SIZE_LOG);
                    remain_q <= remain_q - {19'd0, burst_q};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_wire_data       = '0;
        o_wire_data_valid = '0;
        if (state == ST_DATA) begin
            o_wire_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = i_wire_M_AXI_RDATA;
            o_wire_data_valid[idx_q]                          = i_wire_M_AXI_RVALID;
        end
    end

    assign o_wire_busy          = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);
    assign o_wire_done          = (state == ST_DONE);
    assign o_wire_error         = (state == ST_ERROR);
    assign o_wire_error_type    = error_type_q;
    assign o_wire_M_AXI_ARID    = 1'b0;
    assign o_wire_M_AXI_ARADDR  = araddr_q;
    assign o_wire_M_AXI_ARLEN   = arlen_q;
    assign o_wire_M_AXI_ARSIZE  = 3'(SIZE_LOG);
    assign o_wire_M_AXI_ARBURST = 2'b01;
    assign o_wire_M_AXI_ARLOCK  = 1'b0;
    assign o_wire_M_AXI_ARCACHE = 4'b0010;
    assign o_wire_M_AXI_ARPROT  = 3'b000;
    assign o_wire_M_AXI_ARQOS   = 4'b0000;
    assign o_wire_M_AXI_ARVALID = arvalid_q;
    assign o_wire_M_AXI_RREADY  = r_rdy;
endmodule

// File: tb/tb_painterengine_gpu_dma_reader_mc.sv
// Bench for the multi-channel read DMA: a cycle-stepped AXI slave plus a transfer-level
// model (burst list and expected beat stream derived from address/length alone).
module tb_painterengine_gpu_dma_reader_mc;
    localparam int CH = 4;
    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, ack;
    logic [CH-1:0]  router, data_valid, data_next;
    logic [CH*32-1:0] address, length;
    logic [CH*DW-1:0] data;
    logic           busy, done, error;
    logic [2:0]     err_type;
    logic           arid, arlock, arvalid, arready;
    logic [31:0]    araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize, arprot;
    logic [1:0]     arburst, rresp;
    logic [3:0]     arcache, arqos;
    logic           rid, rlast, rvalid, rready;
    logic [DW-1:0]  rdata;

    painterengine_gpu_dma_reader_mc #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .MAX_BURST(256), .TIMEOUT_BITS(6)
    ) dut (
        .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start), .i_wire_ack(ack),
        .i_wire_router(router), .i_wire_address(address), .i_wire_length(length),
        .o_wire_data(data), .o_wire_data_valid(data_valid), .i_wire_data_next(data_next),
        .o_wire_busy(busy), .o_wire_done(done), .o_wire_error(error),
        .o_wire_error_type(err_type),
        .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr), .o_wire_M_AXI_ARLEN(arlen),
        .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst),
        .o_wire_M_AXI_ARLOCK(arlock), .o_wire_M_AXI_ARCACHE(arcache),
        .o_wire_M_AXI_ARPROT(arprot), .o_wire_M_AXI_ARQOS(arqos),
        .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
        .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
        .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid),
        .o_wire_M_AXI_RREADY(rready)
    );

    int n_pass = 0;
    int n_total = 0;
    int mode, rdy_pct, sel, n_beats, ar_count, ar_cycles, first_ar, step_idx, exp_nb, exp_len;
    int s_len, s_beat;
    bit s_active, r_hs, final_prev;
    logic [31:0] base, s_addr;
    logic [31:0] exp_ar_addr[$];
    logic [7:0]  exp_ar_len[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] pattern(input logic [31:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    // Transfer model: split [a, a+len*8) into bursts of at most 256 beats that never cross 4 KB.
    task automatic setup(input logic [3:0] rt, input int s, input logic [31:0] a, input int len,
                         input int md, input int pct);
        logic [31:0] ma;
        int mr, b, lim;
        router = rt; sel = s; base = a; exp_len = len; mode = md; rdy_pct = pct;
        for (int i = 0; i < CH; i++) begin
            address[i*32 +: 32] = $urandom;
            length[i*32 +: 32]  = $urandom;
        end
        address[s*32 +: 32] = a;
        length[s*32 +: 32]  = 32'(len);
        exp_ar_addr.delete();
        exp_ar_len.delete();
        ma = a; mr = len;
        while (mr > 0) begin
            lim = (4096 - int'(ma[11:0])) / 8;
            b = mr;
            if (b > 256) b = 256;
            if (b > lim) b = lim;
            exp_ar_addr.push_back(ma);
            exp_ar_len.push_back(8'(b - 1));
            ma += 32'(b * 8);
            mr -= b;
        end
        exp_nb = exp_ar_addr.size();
        n_beats = 0; ar_count = 0; ar_cycles = 0; first_ar = -1; step_idx = 0;
        s_active = 0; r_hs = 0; final_prev = 0;
        rvalid = 0; rlast = 0; rresp = 0; arready = 0;
    endtask

    // One clock: entered at a negedge, drives inputs, samples #1 later, returns at next negedge.
    task automatic step();
        if (r_hs) begin
            r_hs = 0; rvalid = 0; s_beat++;
            if (s_beat > s_len) s_active = 0;
        end
        arready = (mode != 4) && !s_active && ($urandom_range(99) < 70);
        for (int i = 0; i < CH; i++) data_next[i] = ($urandom_range(99) < rdy_pct);
        if (s_active && !rvalid && mode != 5 && $urandom_range(99) < 75) begin
            rvalid = 1;
            rdata  = pattern(s_addr + 32'(s_beat * 8));
            rlast  = (s_beat == s_len);
            if (mode == 1 && s_beat == 2) rlast = 1;
            if (mode == 2 && s_beat == s_len) rlast = 0;
            rresp  = (mode == 3 && s_beat == 0) ? 2'b10 : 2'b00;
        end
        #1;
        if (arvalid) ar_cycles++;
        if (arvalid && first_ar < 0) first_ar = step_idx;
        check("valid_vec", data_valid, (rvalid && busy) ? (4'b0001 << sel) : 4'b0000);
        check("beat_eq", rvalid && rready, data_valid[sel] && data_next[sel]);
        if (arvalid && arready) begin
            check("ar_fixed", {arid, arsize, arburst, arlock, arcache, arprot, arqos},
                  {1'b0, 3'd3, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
            if (exp_ar_addr.size() > 0) begin
                check("ar_addr", araddr, exp_ar_addr.pop_front());
                check("ar_len", arlen, exp_ar_len.pop_front());
            end
            ar_count++;
            s_active = 1; s_addr = araddr; s_len = int'(arlen); s_beat = 0;
        end
        if (rvalid && rready) begin
            r_hs = 1;
            check("rdata", data, 256'(pattern(base + 32'(n_beats * 8))) << (sel * 64));
            n_beats++;
            if (mode == 0 && n_beats == exp_len) final_prev = 1;
        end
        step_idx++;
        @(negedge clk);
    endtask

    task automatic run(input int budget, input int abort);
        int cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (!(done || error) && cyc < budget && !(abort > 0 && n_beats >= abort)) begin
            step();
            cyc++;
            if (final_prev) begin
                check("done_after_last", done, 1'b1);
                final_prev = 0;
            end
        end
        check("run_bound", cyc < budget, 1'b1);
    endtask

    task automatic expect_end(input logic [2:0] et, input int ars, input int beats);
        check("status", {done, error}, (et == 3'd0) ? 2'b10 : 2'b01);
        check("error_type", err_type, et);
        check("ar_count", ar_count, ars);
        check("beats", n_beats, beats);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("ack_idle", {busy, done, error, err_type}, 6'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_status"}, {busy, done, error, err_type}, 6'd0);
        check({tag, "_ar"}, {arvalid, araddr, arlen}, 41'd0);
        check({tag, "_data"}, {data_valid, data, rready}, 261'd0);
    endtask

    initial begin
        logic [31:0] ra;
        rst = 1; start = 0; ack = 0; router = '0; address = '0; length = '0;
        data_next = 4'hF; arready = 0; rid = 0; rdata = 64'hDEAD_BEEF_0123_4567;
        rresp = 0; rlast = 0; rvalid = 1;
        mode = 0; rdy_pct = 100; sel = 0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rvalid = 0;
        rst = 0;

        setup(4'b0100, 2, 32'h0000_1000, 16, 0, 100);
        run(2000, 0);
        check("start_to_arvalid", first_ar, 3);
        expect_end(3'd0, exp_nb, 16);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored_in_done", {done, busy}, 2'b10);
        do_ack();

        setup(4'b0001, 0, 32'h0000_0FF0, 300, 0, 60);
        run(4000, 0);
        expect_end(3'd0, 3, 300);
        do_ack();

        for (int t = 0; t < 5; t++) begin
            int c;
            c  = $urandom_range(CH - 1);
            ra = $urandom & 32'h00FF_FFF8;
            if (t[0]) ra = ra | 32'h0000_0F80;
            setup(4'b0001 << c, c, ra, $urandom_range(1, 600), 0, $urandom_range(55, 100));
            run(6000, 0);
            expect_end(3'd0, exp_nb, exp_len);
            do_ack();
        end

        setup(4'b0110, 1, 32'h0000_1000, 8, 0, 100);
        run(100, 0);
        expect_end(3'd1, 0, 0);
        do_ack();
        setup(4'b0010, 1, 32'h0000_1002, 8, 0, 100);
        run(100, 0);
        expect_end(3'd2, 0, 0);
        do_ack();
        setup(4'b1000, 3, 32'h0000_1000, 0, 0, 100);
        run(100, 0);
        expect_end(3'd2, 0, 0);
        do_ack();

        setup(4'b0010, 1, 32'h0000_2000, 8, 1, 100);
        run(500, 0);
        expect_end(3'd5, 1, 3);
        do_ack();
        setup(4'b0010, 1, 32'h0000_2000, 8, 2, 100);
        run(500, 0);
        expect_end(3'd5, 1, 8);
        do_ack();
        setup(4'b0001, 0, 32'h0000_2000, 8, 3, 100);
        run(500, 0);
        expect_end(3'd6, 1, 1);
        do_ack();

        setup(4'b0100, 2, 32'h0000_4000, 8, 4, 100);
        run(500, 0);
        expect_end(3'd3, 0, 0);
        check("ar_timeout_window", (ar_cycles >= 32) && (ar_cycles <= 34), 1'b1);
        do_ack();
        setup(4'b0100, 2, 32'h0000_4000, 8, 5, 100);
        run(500, 0);
        expect_end(3'd4, 1, 0);
        do_ack();

        setup(4'b1000, 3, 32'h0000_3000, 40, 0, 80);
        run(3000, 4);
        check("beats_before_reset", n_beats, 4);
        rst = 1'b1;
        step();
        check_quiet("mid_reset");
        rst = 1'b0;
        setup(4'b1000, 3, 32'h0000_3000, 40, 0, 80);
        run(3000, 0);
        expect_end(3'd0, 1, 40);
        do_ack();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
